// File: rtl/divider_pkg.sv
// Shared definitions for the iterative DIV/IDIV unit: FSM state encoding
// and the per-width iteration counts.
package divider_pkg;

   localparam int unsigned DIV_STATE_W  = 3;
   localparam int unsigned DIV_ITERS_8  = 8;
   localparam int unsigned DIV_ITERS_16 = 16;

   typedef enum logic [DIV_STATE_W-1:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      ITER  = 3'd2,
      FIXUP = 3'd3,
      DONE  = 3'd4
   } DivState_t;

endpackage

// File: rtl/divider.sv
// Iterative restoring divider for DIV/IDIV, one quotient bit per clock.
// Handles AX / r8 and DX:AX / r16, signed and unsigned.
// Optional: define DIVIDER_FULL_RANGE_EN to accept signed quotients of
// -2^(N-1) (80186 behaviour); otherwise they raise a divide error (8086).
module divider
   import divider_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        is_8_bit,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        busy,
   output logic        complete,
   output logic        error
);

   DivState_t   state_q, state_d;
   logic        is8_q, is8_d, sgn_q, sgn_d;
   logic [31:0] dvd_q, dvd_d;
   logic [15:0] dvs_q, dvs_d;
   logic [15:0] dvsr_q, dvsr_d;      // divisor magnitude
   logic [15:0] lo_q, lo_d;          // remaining dividend bits, MSB first
   logic [16:0] prem_q, prem_d;      // partial remainder, N+1 bits
   logic [31:0] qacc_q, qacc_d;      // quotient accumulator, 2N bits
   logic [3:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
   logic [15:0] quotient_q, quotient_d, remainder_q, remainder_d;
   logic        error_q, error_d, busy_q, busy_d, complete_q, complete_d;

   logic        dvd_neg, dvs_neg;
   logic [15:0] dvd_abs16, dvs_abs16, hi;
   logic [7:0]  dvs_abs8;
   logic [31:0] dvd_abs32, dvd_mag;
   logic [15:0] dvs_mag;
   logic [17:0] step;
   logic [15:0] q_fix, r_fix;
   logic [31:0] u_lim, s_lim;
   logic        ovf;

   // One restoring step: trial-subtract the divisor from {prem, next bit};
   // returns {new partial remainder, quotient bit}.
   function automatic logic [17:0] restore_step(input logic [16:0] prem,
                                                input logic        nbit,
                                                input logic [15:0] dvsr);
      logic [17:0] diff;
      diff = {prem, nbit} - {2'b00, dvsr};
      if (diff[17]) restore_step = {prem[15:0], nbit, 1'b0};
      else          restore_step = {diff[16:0], 1'b1};
   endfunction

   // FSM next state and datapath next values
   always_comb begin
      state_d     = state_q;
      is8_d       = is8_q;
      sgn_d       = sgn_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      dvsr_d      = dvsr_q;
      lo_d        = lo_q;
      prem_d      = prem_q;
      qacc_d      = qacc_q;
      cnt_d       = cnt_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      zero_d      = zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      error_d     = error_q;

      // operand sign and magnitude, consumed in PREP
      dvd_neg   = sgn_q & (is8_q ? dvd_q[15] : dvd_q[31]);
      dvs_neg   = sgn_q & (is8_q ? dvs_q[7]  : dvs_q[15]);
      dvd_abs16 = dvd_neg ? -dvd_q[15:0] : dvd_q[15:0];
      dvd_abs32 = dvd_neg ? -dvd_q : dvd_q;
      dvd_mag   = is8_q ? {16'h0000, dvd_abs16} : dvd_abs32;
      dvs_abs8  = dvs_neg ? -dvs_q[7:0] : dvs_q[7:0];
      dvs_abs16 = dvs_neg ? -dvs_q : dvs_q;
      dvs_mag   = is8_q ? {8'h00, dvs_abs8} : dvs_abs16;
      hi        = is8_q ? {8'h00, dvd_mag[15:8]} : dvd_mag[31:16];

      step = restore_step(prem_q, lo_q[15], dvsr_q);

      // sign fixup and range check, consumed in FIXUP
      q_fix = qneg_q ? -qacc_q[15:0] : qacc_q[15:0];
      r_fix = rneg_q ? -prem_q[15:0] : prem_q[15:0];
      if (is8_q) begin
         q_fix[15:8] = '0;
         r_fix[15:8] = '0;
      end
      u_lim = is8_q ? 32'h0000_00FF : 32'h0000_FFFF;
      s_lim = is8_q ? 32'h0000_007F : 32'h0000_7FFF;
`ifdef DIVIDER_FULL_RANGE_EN
      if (qneg_q) s_lim = s_lim + 32'd1;
`endif
      ovf = sgn_q ? (qacc_q > s_lim) : (qacc_q > u_lim);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PREP;
               is8_d   = is_8_bit;
               sgn_d   = is_signed;
               dvd_d   = dividend;
               dvs_d   = divisor;
               error_d = 1'b0;
            end
         end
         PREP: begin
            dvsr_d = dvs_mag;
            prem_d = {1'b0, hi};
            lo_d   = is8_q ? {dvd_mag[7:0], 8'h00} : dvd_mag[15:0];
            // Upper dividend half >= divisor means the quotient needs more
            // than N bits; seeding bit 0 lands it at bit N after N shifts.
            qacc_d = {31'b0, hi >= dvs_mag};
            cnt_d  = is8_q ? 4'(DIV_ITERS_8 - 1) : 4'(DIV_ITERS_16 - 1);
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
            zero_d = (dvs_mag == '0);
            // Zero divisor still passes through FIXUP so that all results
            // and the error flag are registered in one place.
            state_d = (dvs_mag == '0) ? FIXUP : ITER;
         end
         ITER: begin
            prem_d = step[17:1];
            qacc_d = {qacc_q[30:0], step[0]};
            lo_d   = {lo_q[14:0], 1'b0};
            if (cnt_q == '0) state_d = FIXUP;
            else             cnt_d   = cnt_q - 4'd1;
         end
         FIXUP: begin
            if (zero_q || ovf) begin
               quotient_d  = '0;
               remainder_d = '0;
               error_d     = 1'b1;
            end else begin
               quotient_d  = q_fix;
               remainder_d = r_fix;
               error_d     = 1'b0;
            end
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d     = (state_d == PREP) || (state_d == ITER) || (state_d == FIXUP);
      complete_d = (state_d == DONE);
   end

   // State and datapath registers; reset aborts any divide in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         is8_q       <= 1'b0;
         sgn_q       <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         dvsr_q      <= '0;
         lo_q        <= '0;
         prem_q      <= '0;
         qacc_q      <= '0;
         cnt_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         zero_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
         complete_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         is8_q       <= is8_d;
         sgn_q       <= sgn_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         dvsr_q      <= dvsr_d;
         lo_q        <= lo_d;
         prem_q      <= prem_d;
         qacc_q      <= qacc_d;
         cnt_q       <= cnt_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         zero_q      <= zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         error_q     <= error_d;
         busy_q      <= busy_d;
         complete_q  <= complete_d;
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign busy      = busy_q;
   assign complete  = complete_q;
   assign error     = error_q;

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider. Latency is counted with start
// sampled at edge 0; complete "at cycle k" is seen between edges k-1 and k.
module tb_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        is_8_bit = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic [15:0] quotient, remainder;
   logic        busy, complete, error;

   int compared = 0;
   int mismatched = 0;
   int lat;
   logic busy1;
   int hits;

   always #5 clk = ~clk;

   divider dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .is_8_bit(is_8_bit), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .complete(complete), .error(error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one divide, scramble inputs after acceptance, optionally pulse
   // start mid-operation, and return at the complete cycle (or -1 latency).
   task automatic run_op(input logic s8, input logic sg, input logic [31:0] dvd,
                         input logic [15:0] dvs, input logic poke,
                         output int lat_o, output logic busy_o);
      @(negedge clk);
      is_8_bit = s8; is_signed = sg; dividend = dvd; divisor = dvs; start = 1'b1;
      @(negedge clk);
      start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 16'h5A5A;
      is_8_bit = ~s8; is_signed = ~sg;
      lat_o = -1;
      busy_o = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 1) busy_o = busy;
         if (complete) begin
            lat_o = c;
            break;
         end
         if (poke && c == 4) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      // reset values
      #2;
      check("rst_q",  32'(quotient),  32'h0);
      check("rst_r",  32'(remainder), 32'h0);
      check("rst_busy", 32'(busy),    32'h0);
      check("rst_cmp",  32'(complete), 32'h0);
      check("rst_err",  32'(error),   32'h0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;

      // unsigned 16-bit 0x0001_0005 / 0x0010
      run_op(1'b0, 1'b0, 32'h0001_0005, 16'h0010, 1'b0, lat, busy1);
      check("u16_lat", 32'(lat), 32'd19);
      check("u16_busy1", 32'(busy1), 32'h1);
      check("u16_busy_done", 32'(busy), 32'h0);
      check("u16_q", 32'(quotient), 32'h1000);
      check("u16_r", 32'(remainder), 32'h0005);
      check("u16_err", 32'(error), 32'h0);
      @(negedge clk);
      check("u16_pulse", 32'(complete), 32'h0);

      // signed 8-bit -7 / 2
      run_op(1'b1, 1'b1, 32'h0000_FFF9, 16'h0002, 1'b0, lat, busy1);
      check("s8_lat", 32'(lat), 32'd11);
      check("s8_q", 32'(quotient), 32'h00FD);
      check("s8_r", 32'(remainder), 32'h00FF);
      check("s8_err", 32'(error), 32'h0);

      // divide by zero, 16-bit and signed 8-bit
      run_op(1'b0, 1'b0, 32'h1234_5678, 16'h0000, 1'b0, lat, busy1);
      check("dz16_lat", 32'(lat), 32'd3);
      check("dz16_err", 32'(error), 32'h1);
      check("dz16_q", 32'(quotient), 32'h0);
      check("dz16_r", 32'(remainder), 32'h0);
      repeat (3) @(negedge clk);
      check("dz16_err_held", 32'(error), 32'h1);
      run_op(1'b1, 1'b1, 32'h0000_FF80, 16'hFF00, 1'b0, lat, busy1);
      check("dz8_lat", 32'(lat), 32'd3);
      check("dz8_err", 32'(error), 32'h1);

      // unsigned 8-bit overflow 0x0200 / 2
      run_op(1'b1, 1'b0, 32'h0000_0200, 16'h0002, 1'b0, lat, busy1);
      check("ov8u_lat", 32'(lat), 32'd11);
      check("ov8u_err", 32'(error), 32'h1);
      check("ov8u_q", 32'(quotient), 32'h0);

      // signed 16-bit -32768 / 1
      run_op(1'b0, 1'b1, 32'hFFFF_8000, 16'h0001, 1'b0, lat, busy1);
      check("s16min_lat", 32'(lat), 32'd19);
`ifdef DIVIDER_FULL_RANGE_EN
      check("s16min_err", 32'(error), 32'h0);
      check("s16min_q", 32'(quotient), 32'h8000);
`else
      check("s16min_err", 32'(error), 32'h1);
      check("s16min_q", 32'(quotient), 32'h0);
`endif
      check("s16min_r", 32'(remainder), 32'h0);

      // signed 8-bit -128 / 1 and +128 / 1
      run_op(1'b1, 1'b1, 32'h0000_FF80, 16'h0001, 1'b0, lat, busy1);
`ifdef DIVIDER_FULL_RANGE_EN
      check("s8min_err", 32'(error), 32'h0);
      check("s8min_q", 32'(quotient), 32'h0080);
`else
      check("s8min_err", 32'(error), 32'h1);
      check("s8min_q", 32'(quotient), 32'h0);
`endif
      run_op(1'b1, 1'b1, 32'h0000_0080, 16'h0001, 1'b0, lat, busy1);
      check("s8pos_ovf", 32'(error), 32'h1);

      // signed 16-bit sign combinations: 100 / -7, -100 / 7
      run_op(1'b0, 1'b1, 32'h0000_0064, 16'hFFF9, 1'b0, lat, busy1);
      check("s16a_q", 32'(quotient), 32'hFFF2);
      check("s16a_r", 32'(remainder), 32'h0002);
      check("s16a_err", 32'(error), 32'h0);
      run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 16'h0007, 1'b0, lat, busy1);
      check("s16b_q", 32'(quotient), 32'hFFF2);
      check("s16b_r", 32'(remainder), 32'hFFFE);

      // unsigned range edges: largest legal quotients, and first overflow
      run_op(1'b0, 1'b0, 32'hFFFE_0001, 16'hFFFF, 1'b0, lat, busy1);
      check("u16max_q", 32'(quotient), 32'hFFFF);
      check("u16max_r", 32'(remainder), 32'h0);
      check("u16max_err", 32'(error), 32'h0);
      run_op(1'b0, 1'b0, 32'hFFFF_0000, 16'hFFFF, 1'b0, lat, busy1);
      check("u16ovf_err", 32'(error), 32'h1);
      run_op(1'b1, 1'b0, 32'h0000_FEFF, 16'h00FF, 1'b0, lat, busy1);
      check("u8max_q", 32'(quotient), 32'h00FF);
      check("u8max_r", 32'(remainder), 32'h00FE);
      check("u8max_err", 32'(error), 32'h0);

      // reset during the 5th ITER cycle of a 16-bit divide
      @(negedge clk);
      is_8_bit = 1'b0; is_signed = 1'b0; dividend = 32'h0001_0005; divisor = 16'h0010;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy_pre", 32'(busy), 32'h1);
      reset_n = 1'b0;
      #1;
      check("mid_busy", 32'(busy), 32'h0);
      check("mid_cmp", 32'(complete), 32'h0);
      check("mid_q", 32'(quotient), 32'h0);
      check("mid_r", 32'(remainder), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (complete) hits++;
      end
      check("mid_no_cmp", 32'(hits), 32'h0);
      run_op(1'b0, 1'b0, 32'd100, 16'd7, 1'b0, lat, busy1);
      check("post_lat", 32'(lat), 32'd19);
      check("post_q", 32'(quotient), 32'd14);
      check("post_r", 32'(remainder), 32'd2);

      // start pulsed while busy and in the complete cycle is ignored
      run_op(1'b0, 1'b0, 32'd1000, 16'd3, 1'b1, lat, busy1);
      check("b2b_lat", 32'(lat), 32'd19);
      check("b2b_q", 32'(quotient), 32'h014D);
      check("b2b_r", 32'(remainder), 32'h0001);
      is_8_bit = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 16'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_cmp_low", 32'(complete), 32'h0);
      check("b2b_not_busy", 32'(busy), 32'h0);
      @(negedge clk);
      check("b2b_still_idle", 32'(busy), 32'h0);
      check("b2b_q_held", 32'(quotient), 32'h014D);

      // immediately following request after complete is accepted
      run_op(1'b1, 1'b0, 32'd50, 16'd5, 1'b0, lat, busy1);
      run_op(1'b1, 1'b0, 32'd51, 16'd5, 1'b0, lat, busy1);
      check("next_lat", 32'(lat), 32'd11);
      check("next_q", 32'(quotient), 32'd10);
      check("next_r", 32'(remainder), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
